vx_vgpr_req_arb: RTL and testbench
==================================

// Module: vx_vgpr_req_arb
// PURPOSE
//  Shares one VGPR bank read port among NUM_REQS operand-collector requesters.
//  - Round-robin arbitration on the request channel.
//  - Routes each in-order response back to the requester that issued it, using a tag FIFO of grant indices.
//  - Sits between the operand collectors and a single VGPR bank. That bank returns responses in order, with no rsp backpressure.
// PARAMETERS
//  NUM_REQS     4   number of requesters (>=2)
//  REQ_DATAW    32  width of packed VGPR request {opd_id,lid,wis,sid,reg_id}
//  RSP_DATAW    130 width of packed VGPR response {opd_id,data}
//  MAX_PENDING  4   max requests accepted but not yet answered (power of 2, >=2)
// PORTS
//  clk            in   1                  clock
//  reset          in   1                  async active-high reset
//  req_valid_in   in   NUM_REQS           per-requester request valid
//  req_data_in    in   NUM_REQS*REQ_DATAW per-requester request payload
//  req_ready_in   out  NUM_REQS           per-requester request accept
//  req_valid_out  out  1                  request to VGPR bank
//  req_data_out   out  REQ_DATAW          payload of granted requester
//  req_ready_out  in   1                  VGPR bank accepts request
//  rsp_valid_in   in   1                  VGPR bank response valid (no ready)
//  rsp_data_in    in   RSP_DATAW          VGPR bank response payload
//  rsp_valid_out  out  NUM_REQS           one-hot response to owning requester
//  rsp_data_out   out  RSP_DATAW          response payload, broadcast to all
//  pending_cnt    out  clog2(MAX_PENDING)+1  outstanding request count
// BEHAVIOUR
//  - Reset (async, active-high): rr_ptr=0, lock=0, tag FIFO empty, pending_cnt=0.
//    All outputs are 0 while reset is asserted.
//  - Grant: round-robin search starting at rr_ptr over req_valid_in.
//    Combinational, zero-cycle path from request inputs to req_*_out.
//  - can_issue = (pending_cnt < MAX_PENDING).
//    req_valid_out = can_issue & (any req_valid_in | lock).
//  - req_ready_in[g] = req_ready_out & can_issue, for the granted index g only. All other bits are 0.
//  - Fire = req_valid_out & req_ready_out. On fire:
//    - push g to the tag FIFO;
//    - rr_ptr <= (g+1) mod NUM_REQS;
//    - lock <= 0.
//  - Lock (two states, IDLE/LOCKED):
//    - IDLE->LOCKED when req_valid_out & !req_ready_out. Store g in lock_idx.
//    - While LOCKED, the grant is held at lock_idx regardless of other requesters, so req_data_out stays stable.
//    - LOCKED->IDLE on fire.
//    - Requesters must hold valid/data until ready; this rule is not checked.
//  - Response: rsp_valid_out[i] = rsp_valid_in & (fifo_head==i). rsp_data_out = rsp_data_in.
//    Combinational path, zero-cycle. Pop the FIFO on rsp_valid_in.
//  - pending_cnt: +1 on fire, -1 on rsp_valid_in. Unchanged when both occur in the same cycle.
//  - Full: when pending_cnt==MAX_PENDING, no grant is issued. A response in that same cycle does not bypass the check.
//    The next cycle's count reflects the pop.
//  - Empty: rsp_valid_in while pending_cnt==0 is a protocol error.
//    Drop it: no rsp_valid_out, counter stays 0. A simulation assertion fires.
//  - FIFO pointers wrap modulo MAX_PENDING.
//  - Reset mid-operation discards all pending tags. Responses arriving after reset are treated under the empty rule.
// CONFIGURATION
//  VX_VGPR_ARB_PERF_EN defined: adds
//    perf_stall_out [31:0] out: cycles with any req_valid_in & !can_issue;
//    perf_conflict_out [31:0] out: cycles with >=2 req_valid_in.
//    Both counters reset to 0 and saturate at 32'hFFFFFFFF.
//  VX_VGPR_ARB_PERF_EN undefined: these ports and counters do not exist. Behaviour is otherwise identical.
// TESTING
//  1. Reset release, no requests -> all outputs 0, pending_cnt=0.
//  2. All 4 requesters valid, req_ready_out=1, rsp returned 2 cycles after each fire
//     -> grant order 0,1,2,3,0.
//     -> each rsp_valid_out one-hot matches issue order.
//  3. req0 valid, req_ready_out=0 for 3 cycles, req1 asserted on cycle 1
//     -> req_data_out = req0 data for all 3 cycles; req0 fires first, req1 fires next.
//  4. MAX_PENDING=4, 4 fires, no rsp -> 5th request stalls; pending_cnt=4.
//     One rsp -> 5th fires the next cycle.
//  5. Fire and rsp in the same cycle with pending_cnt=2 -> pending_cnt stays 2; FIFO order preserved.
//  6. rsp_valid_in with FIFO empty -> rsp_valid_out=0, pending_cnt=0, assertion logged.
//     With VX_VGPR_ARB_PERF_EN, scenario 4 stall -> perf_stall_out increments by 1 per stalled cycle.

Source files
------------

// File: rtl/vx_vgpr_req_arb.sv
// vx_vgpr_req_arb: shares one VGPR bank read port among NUM_REQS operand-collector requesters.
//   - Round-robin request arbitration; a stalled grant is locked until it fires so the bank
//     sees a stable payload.
//   - Grant indices go into a tag FIFO; the bank answers in order, so the FIFO head names the
//     owner of each response.
//   - Up to MAX_PENDING requests may be outstanding; beyond that no grant is issued.
// Optional feature macro: VX_VGPR_ARB_PERF_EN adds perf_stall_out / perf_conflict_out.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req_valid_in/data_in    per-requester request channel (NUM_REQS lanes)
//   req_ready_in            per-requester accept (only the granted lane)
//   req_valid_out/data_out  request towards the VGPR bank, req_ready_out its accept
//   rsp_valid_in/data_in    in-order bank response (no backpressure)
//   rsp_valid_out           one-hot response owner, rsp_data_out broadcast payload
//   pending_cnt             number of accepted-but-unanswered requests
module vx_vgpr_req_arb #(
  parameter int unsigned NUM_REQS    = 4,
  parameter int unsigned REQ_DATAW   = 32,
  parameter int unsigned RSP_DATAW   = 130,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid_in,
  input  logic [NUM_REQS*REQ_DATAW-1:0] req_data_in,
  output logic [NUM_REQS-1:0]           req_ready_in,
  output logic                          req_valid_out,
  output logic [REQ_DATAW-1:0]          req_data_out,
  input  logic                          req_ready_out,
  input  logic                          rsp_valid_in,
  input  logic [RSP_DATAW-1:0]          rsp_data_in,
  output logic [NUM_REQS-1:0]           rsp_valid_out,
  output logic [RSP_DATAW-1:0]          rsp_data_out,
  output logic [$clog2(MAX_PENDING):0]  pending_cnt
`ifdef VX_VGPR_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_stall_out,
  output logic [31:0]                   perf_conflict_out
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_REQS);
  localparam int unsigned PtrW = $clog2(MAX_PENDING);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {StIdle, StLocked} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     lock_idx_q, lock_idx_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     tag_q [MAX_PENDING];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                any_valid;
  logic                can_issue;
  logic                has_req;
  logic                fire;
  logic                pop;
  logic [IdxW-1:0]     rr_gnt;
  logic [IdxW-1:0]     gnt;
  logic                found;
  int                  idx;

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    any_valid = |req_valid_in;
    rr_gnt    = rr_ptr_q;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= int'(NUM_REQS)) idx = idx - int'(NUM_REQS);
      if (!found && req_valid_in[IdxW'(idx)]) begin
        found  = 1'b1;
        rr_gnt = IdxW'(idx);
      end
    end
  end

  // A locked grant overrides the search so the stalled payload stays put.
  assign gnt       = (state_q == StLocked) ? lock_idx_q : rr_gnt;
  assign can_issue = (cnt_q < CntW'(MAX_PENDING));
  assign has_req   = any_valid || (state_q == StLocked);

  assign req_valid_out = !reset && can_issue && has_req;
  assign fire          = req_valid_out && req_ready_out;

  always_comb begin
    req_ready_in = '0;
    req_data_out = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      if (IdxW'(i) == gnt) begin
        req_ready_in[i] = fire;
        if (!reset && has_req) req_data_out = req_data_in[i*REQ_DATAW +: REQ_DATAW];
      end
    end
  end

  // A response with nothing outstanding is dropped rather than popping an empty FIFO.
  assign pop          = !reset && rsp_valid_in && (cnt_q != '0);
  assign rsp_data_out = reset ? '0 : rsp_data_in;

  always_comb begin
    rsp_valid_out = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      rsp_valid_out[i] = pop && (tag_q[rd_ptr_q] == IdxW'(i));
    end
  end

  assign pending_cnt = cnt_q;

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_out && !req_ready_out) begin
          state_d    = StLocked;
          lock_idx_d = gnt;
        end
      end
      StLocked: begin
        if (fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (fire) rr_ptr_d = (gnt == IdxW'(NUM_REQS - 1)) ? '0 : gnt + IdxW'(1);
    unique case ({fire, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < int'(MAX_PENDING); i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      if (fire) begin
        tag_q[wr_ptr_q] <= gnt;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

`ifdef VX_VGPR_ARB_PERF_EN
  logic [31:0] stall_q, conflict_q;
  logic        stall_ev, conflict_ev;

  assign stall_ev    = any_valid && !can_issue;
  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign conflict_ev = ((req_valid_in & (req_valid_in - NUM_REQS'(1))) != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q    <= '0;
      conflict_q <= '0;
    end else begin
      if (stall_ev && (stall_q != '1))       stall_q    <= stall_q + 32'd1;
      if (conflict_ev && (conflict_q != '1)) conflict_q <= conflict_q + 32'd1;
    end
  end

  assign perf_stall_out    = stall_q;
  assign perf_conflict_out = conflict_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(rsp_valid_in && (cnt_q == '0)))
        else $warning("vx_vgpr_req_arb: response with no pending request dropped");
    end
  end
`endif

endmodule

// File: tb/tb_vx_vgpr_req_arb.sv
// Bench for vx_vgpr_req_arb: directed vector table, hand-written reset sequences and a
// randomized run against a queue-based reference model.
module tb_vx_vgpr_req_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 130;
  localparam int MP = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid_in;
  logic [N*DW-1:0]   req_data_in;
  logic [N-1:0]      req_ready_in;
  logic              req_valid_out;
  logic [DW-1:0]     req_data_out;
  logic              req_ready_out;
  logic              rsp_valid_in;
  logic [RW-1:0]     rsp_data_in;
  logic [N-1:0]      rsp_valid_out;
  logic [RW-1:0]     rsp_data_out;
  logic [2:0]        pending_cnt;
`ifdef VX_VGPR_ARB_PERF_EN
  logic [31:0]       perf_stall_out;
  logic [31:0]       perf_conflict_out;
`endif

  vx_vgpr_req_arb #(
    .NUM_REQS   (N),
    .REQ_DATAW  (DW),
    .RSP_DATAW  (RW),
    .MAX_PENDING(MP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_in (req_valid_in),
    .req_data_in  (req_data_in),
    .req_ready_in (req_ready_in),
    .req_valid_out(req_valid_out),
    .req_data_out (req_data_out),
    .req_ready_out(req_ready_out),
    .rsp_valid_in (rsp_valid_in),
    .rsp_data_in  (rsp_data_in),
    .rsp_valid_out(rsp_valid_out),
    .rsp_data_out (rsp_data_out),
    .pending_cnt  (pending_cnt)
`ifdef VX_VGPR_ARB_PERF_EN
    ,
    .perf_stall_out   (perf_stall_out),
    .perf_conflict_out(perf_conflict_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic       rdy;
    logic       rsp;
    logic       vo;
    logic [3:0] rin;
    logic [3:0] rout;
    logic [2:0] cnt;
    int         gnt;
  } vec_t;

  vec_t tab[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: outstanding owners in issue order, round-robin start, lock state.
  int m_q[$];
  int m_rr;
  bit m_lock;
  int m_lidx;

  function automatic vec_t mk(logic [3:0] vld, logic rdy, logic rsp, logic vo, logic [3:0] rin,
                              logic [3:0] rout, logic [2:0] cnt, int gnt);
    vec_t v;
    v.vld = vld; v.rdy = rdy; v.rsp = rsp; v.vo = vo;
    v.rin = rin; v.rout = rout; v.cnt = cnt; v.gnt = gnt;
    return v;
  endfunction

  function automatic logic [DW-1:0] dconst(int i);
    return 32'hA5A5_0000 + DW'(i);
  endfunction

  function automatic int m_grant(logic [3:0] v);
    if (m_lock) return m_lidx;
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rr   = 0;
    m_lock = 0;
    m_lidx = 0;
  endtask

  task automatic drive(input logic [3:0] vld, input logic rdy, input logic rsp);
    logic [159:0] rnd;
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
    req_valid_in  = vld;
    req_ready_out = rdy;
    rsp_valid_in  = rsp;
    rsp_data_in   = rnd[RW-1:0];
  endtask

  // Inputs are already driven; sample at the falling edge, then advance the model.
  task automatic step(input string nm, input bit tab_en, input vec_t t);
    int         g;
    logic       evo, fire, pop;
    logic [3:0] erin, erout;
    @(negedge clk);
    g     = m_grant(req_valid_in);
    evo   = (m_q.size() < MP) && (g >= 0);
    erin  = '0;
    erout = '0;
    if (evo && req_ready_out) erin[g] = 1'b1;
    if (rsp_valid_in && m_q.size() > 0) erout[m_q[0]] = 1'b1;
    chk({nm, "_model"}, 160'({req_valid_out, req_ready_in, rsp_valid_out, pending_cnt}),
        160'({evo, erin, erout, 3'(m_q.size())}));
    if (evo) chk({nm, "_model_data"}, 160'(req_data_out), 160'(req_data_in[g*DW +: DW]));
    chk({nm, "_rsp_data"}, 160'(rsp_data_out), 160'(rsp_data_in));
    if (tab_en) begin
      chk({nm, "_vec"}, 160'({req_valid_out, req_ready_in, rsp_valid_out, pending_cnt}),
          160'({t.vo, t.rin, t.rout, t.cnt}));
      if (t.vo) chk({nm, "_vec_data"}, 160'(req_data_out), 160'(dconst(t.gnt)));
    end
    fire = evo && req_ready_out;
    pop  = rsp_valid_in && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (fire) begin
      m_q.push_back(g);
      m_rr   = (g + 1) % N;
      m_lock = 0;
    end else if (evo) begin
      m_lock = 1;
      m_lidx = g;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   s4_first;
    vec_t dummy;
`ifdef VX_VGPR_ARB_PERF_EN
    logic [31:0] snap;
`endif
    dummy = mk(0, 0, 0, 0, 0, 0, 0, 0);

    // Scenario 1: idle after reset.
    tab.push_back(mk(4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 0));
    // Scenario 2 (and fire+rsp at count 2): all valid, responses two cycles after each fire.
    tab.push_back(mk(4'hF, 1, 0, 1, 4'h1, 4'h0, 0, 0));
    tab.push_back(mk(4'hF, 1, 0, 1, 4'h2, 4'h0, 1, 1));
    tab.push_back(mk(4'hF, 1, 1, 1, 4'h4, 4'h1, 2, 2));
    tab.push_back(mk(4'hF, 1, 1, 1, 4'h8, 4'h2, 2, 3));
    tab.push_back(mk(4'hF, 1, 1, 1, 4'h1, 4'h4, 2, 0));
    tab.push_back(mk(4'h0, 1, 1, 0, 4'h0, 4'h8, 2, 0));
    tab.push_back(mk(4'h0, 1, 1, 0, 4'h0, 4'h1, 1, 0));
    tab.push_back(mk(4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 0));
    // Scenario 3: req0 stalled three cycles, req1 joins; lock keeps req0 granted.
    tab.push_back(mk(4'h1, 0, 0, 1, 4'h0, 4'h0, 0, 0));
    tab.push_back(mk(4'h3, 0, 0, 1, 4'h0, 4'h0, 0, 0));
    tab.push_back(mk(4'h3, 0, 0, 1, 4'h0, 4'h0, 0, 0));
    tab.push_back(mk(4'h3, 1, 0, 1, 4'h1, 4'h0, 0, 0));
    tab.push_back(mk(4'h2, 1, 0, 1, 4'h2, 4'h0, 1, 1));
    tab.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h1, 2, 0));
    tab.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h2, 1, 0));
    // Scenario 4: fill to MAX_PENDING, stall, one response, then the stalled request fires.
    tab.push_back(mk(4'hF, 1, 0, 1, 4'h4, 4'h0, 0, 2));
    tab.push_back(mk(4'hF, 1, 0, 1, 4'h8, 4'h0, 1, 3));
    tab.push_back(mk(4'hF, 1, 0, 1, 4'h1, 4'h0, 2, 0));
    tab.push_back(mk(4'hF, 1, 0, 1, 4'h2, 4'h0, 3, 1));
    s4_first = tab.size();
    tab.push_back(mk(4'hF, 1, 0, 0, 4'h0, 4'h0, 4, 0));
    tab.push_back(mk(4'hF, 1, 0, 0, 4'h0, 4'h0, 4, 0));
    tab.push_back(mk(4'hF, 1, 1, 0, 4'h0, 4'h4, 4, 0));
    tab.push_back(mk(4'hF, 1, 0, 1, 4'h4, 4'h0, 3, 2));
    tab.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h8, 4, 0));
    tab.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h1, 3, 0));
    tab.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h2, 2, 0));
    tab.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h4, 1, 0));
    // Scenario 6: response with nothing outstanding is dropped.
    tab.push_back(mk(4'h0, 0, 1, 0, 4'h0, 4'h0, 0, 0));
    tab.push_back(mk(4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 0));

    // Outputs stay 0 while reset is asserted even with active inputs.
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) req_data_in[i*DW +: DW] = dconst(i);
    drive(4'hF, 1'b1, 1'b1);
    #1;
    chk("reset_ctrl", 160'({req_valid_out, req_ready_in, rsp_valid_out, pending_cnt}), 160'(0));
    chk("reset_req_data", 160'(req_data_out), 160'(0));
    chk("reset_rsp_data", 160'(rsp_data_out), 160'(0));
    drive(4'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i].vld, tab[i].rdy, tab[i].rsp);
`ifdef VX_VGPR_ARB_PERF_EN
      if (i == s4_first) snap = perf_stall_out;
`endif
      step($sformatf("row%0d", i), 1'b1, tab[i]);
`ifdef VX_VGPR_ARB_PERF_EN
      if (i == s4_first + 2) chk("perf_stall", 160'(perf_stall_out), 160'(snap + 32'd3));
`endif
    end

    // Reset in the middle of operation discards outstanding tags.
    drive(4'hF, 1'b1, 1'b0);
    step("mid_a", 1'b0, dummy);
    step("mid_b", 1'b0, dummy);
    drive(4'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_reset_cnt", 160'(pending_cnt), 160'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(4'h0, 1'b0, 1'b1);
    step("post_reset_rsp", 1'b1, mk(4'h0, 0, 1, 0, 4'h0, 4'h0, 0, 0));
    drive(4'h0, 1'b0, 1'b0);
    step("post_reset_idle", 1'b1, mk(4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 0));

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      req_data_in = {$urandom, $urandom, $urandom, $urandom};
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
            (m_q.size() > 0) && ($urandom_range(0, 9) < 4));
      step("rand", 1'b0, dummy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
